// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

  // One buffered fetch: the word plus the PC it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
interface if_fetch_queue_if;
  import if_fetch_queue_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;

  // Fetch unit side.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  // Memory side.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Generic synchronous FIFO with flush; pop on empty and push on full
// (without a simultaneous pop) are ignored.
module if_fetch_queue_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array; not reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking; flush behaves like a reset of the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues in-order imem reads,
// buffers returned words with their PC and presents the head to IF/ID.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  if_fetch_queue_if.master      imem,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  input  logic                  id_ready,
  output logic                  if_valid,
  output logic [INSTR_W-1:0]    if_instr,
  output logic [ADDR_W-1:0]     if_pc,
  output logic [ADDR_W-1:0]     if_pc_plus4
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] redirect_al;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              issue_fire;
  logic              push;
  logic              pop;
  logic              credit_ok;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign redirect_al = word_align(redirect_pc);

  // Entries already queued plus live (non-dropped) requests in flight must
  // leave room, so every response that is kept always finds a free slot.
  assign credit_ok = (int'(count) + int'(outstanding) - int'(drop_cnt)) < DEPTH;

  assign imem.imem_req_valid = !rst && !redirect_valid
                               && (int'(outstanding) < MAX_OUTSTANDING) && credit_ok;
  assign imem.imem_req_addr  = fetch_pc;
  assign issue_fire          = imem.imem_req_valid && imem.imem_req_ready;

  assign push = imem.imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop  = if_valid && id_ready && !redirect_valid;

  assign wr_entry.pc    = resp_pc;
  assign wr_entry.instr = imem.imem_resp_data;

  if_fetch_queue_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // PC, in-flight and drop bookkeeping; a redirect overrides normal advance
  // and marks every still-unreturned request as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(issue_fire) - OW'(imem.imem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_al;
        resp_pc  <= redirect_al;
        drop_cnt <= outstanding - OW'(imem.imem_resp_valid);
      end else begin
        if (issue_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (push) begin
          resp_pc <= resp_pc + PC_STEP;
        end else if (imem.imem_resp_valid) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

  assign if_valid    = !rst && !empty;
  assign if_instr    = if_valid ? head.instr : NOP;
  assign if_pc       = if_valid ? head.pc : '0;
  assign if_pc_plus4 = if_valid ? head.pc + PC_STEP : '0;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
